ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 166 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch front end: walks the program counter line by line, asks
// the instruction cache for each line, and buffers the returned fetch groups
// in a small FIFO for the decode stage. A redirect (load_pc) flushes the FIFO
// and restarts fetching at the new target. Slots of the first group after a
// redirect that lie below the target word are marked invalid.
//
// Ports
//   clock             single clock, all state on the rising edge
//   reset_n           asynchronous active-low reset
//   cache_addr        fetch address (the current pc)
//   cache_rd          fetch request, high while not redirecting and not full
//   cache_data        line data, word 0 in the MSBs
//   cache_waitrequest request not accepted / data invalid while high
//   load_pc           redirect strobe, wins over everything else
//   new_pc            redirect target, bits [1:0] ignored
//   out_valid         head fetch group present
//   out_ready         consumer accepts the head group
//   inst_word         head group words, word 0 in the MSBs
//   inst_valid        per-slot valid, bit i is slot i
//   pc_out            per-slot pc, slot 0 in the MSBs
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic [31:0]              cache_addr,
  output logic                     cache_rd,
  input  logic [32*FETCH_WIDTH-1:0] cache_data,
  input  logic                     cache_waitrequest,
  input  logic                     load_pc,
  input  logic [31:0]              new_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*FETCH_WIDTH-1:0] inst_word,
  output logic [FETCH_WIDTH-1:0]   inst_valid,
  output logic [32*FETCH_WIDTH-1:0] pc_out
);

  // OFF is the number of byte-offset bits inside one cache line; the word
  // index within the line is pc[OFF-1:2] and the line tag is pc[31:OFF].
  localparam int unsigned OFF  = $clog2(FETCH_WIDTH) + 2;
  localparam int unsigned IDXW = OFF - 2;
  localparam int unsigned TAGW = 32 - OFF;
  localparam int unsigned PTRW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(QUEUE_DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;

  // Entry storage. Only the line tag is kept per entry; the per-slot pcs are
  // rebuilt from it on the way out, since they differ only in the word index.
  logic [32*FETCH_WIDTH-1:0] words_q [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0]    valid_q [QUEUE_DEPTH];
  logic [TAGW-1:0]           tag_q   [QUEUE_DEPTH];

  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 pop;
  logic [TAGW-1:0]      lineTag;
  logic [IDXW-1:0]      pcIdx;
  logic [FETCH_WIDTH-1:0] pushValid;

  assign lineTag = pc_q[31:OFF];
  assign pcIdx   = pc_q[OFF-1:2];

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // The request is withdrawn during a redirect so the stale line at the old
  // pc can never be pushed; a full queue also blocks the push even if a pop
  // is happening in the same cycle.
  assign cache_rd   = ~load_pc & ~full;
  assign accept     = cache_rd & ~cache_waitrequest;
  assign pop        = ~empty & out_ready & ~load_pc;
  assign cache_addr = pc_q;
  assign out_valid  = ~empty;

  // Slots below the current word index are not part of the instruction
  // stream (only relevant for the first line after a redirect, because
  // every accept moves pc to a line boundary).
  always_comb begin
    pushValid = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      pushValid[i] = (IDXW'(i) >= pcIdx);
    end
  end

  // Next-state logic for pc, occupancy and pointers. The redirect branch
  // overrides every other event, including a same-cycle pop.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (load_pc) begin
      pc_d    = new_pc & ~32'h0000_0003;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (accept) begin
        pc_d   = {lineTag + TAGW'(1), {OFF{1'b0}}};
        tail_d = tail_q + PTRW'(1);
      end
      if (pop) begin
        head_d = head_q + PTRW'(1);
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage has no reset: the outputs are forced to zero while the
  // queue is empty, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (accept) begin
      words_q[tail_q] <= cache_data;
      valid_q[tail_q] <= pushValid;
      tag_q[tail_q]   <= lineTag;
    end
  end

  // Head group presentation, straight from storage with no path from
  // cache_data.
  always_comb begin
    inst_word  = '0;
    inst_valid = '0;
    pc_out     = '0;
    if (!empty) begin
      inst_word  = words_q[head_q];
      inst_valid = valid_q[head_q];
      for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
        pc_out[32*(int'(FETCH_WIDTH)-i)-1 -: 32] = {tag_q[head_q], IDXW'(i), 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//
// Directed bench for ifetch_queue with FETCH_WIDTH=4, QUEUE_DEPTH=4,
// RESET_PC=0. A tiny cache model returns a line whose words are derived from
// the line address, so every expected group can be written down from the
// address alone.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;

  localparam int GW = 1 + 4 + 128 + 128;
  localparam logic [GW-1:0] EMPTY_GROUP = '0;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic [31:0]  cache_addr;
  logic         cache_rd;
  logic [127:0] cache_data;
  logic         cache_waitrequest = 1'b0;
  logic         load_pc = 1'b0;
  logic [31:0]  new_pc = 32'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] inst_word;
  logic [3:0]   inst_valid;
  logic [127:0] pc_out;
  logic [GW-1:0] headObs;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  ifetch_queue #(
    .FETCH_WIDTH(4),
    .QUEUE_DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cache_addr(cache_addr),
    .cache_rd(cache_rd),
    .cache_data(cache_data),
    .cache_waitrequest(cache_waitrequest),
    .load_pc(load_pc),
    .new_pc(new_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .inst_word(inst_word),
    .inst_valid(inst_valid),
    .pc_out(pc_out)
  );

  function automatic logic [127:0] lineData(input logic [31:0] base);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[127-32*i -: 32] = (base + 32'(4*i)) ^ 32'hC0DE_0000;
    return r;
  endfunction

  function automatic logic [127:0] linePcs(input logic [31:0] base);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[127-32*i -: 32] = base + 32'(4*i);
    return r;
  endfunction

  function automatic logic [GW-1:0] group(input logic [31:0] base, input logic [3:0] v);
    return {1'b1, v, linePcs(base), lineData(base)};
  endfunction

  // Cache model: returns garbage while stalling so a wrong push is visible.
  assign cache_data = cache_waitrequest ? {4{32'hBADB_AD00}} : lineData({cache_addr[31:4], 4'h0});
  assign headObs    = {out_valid, inst_valid, pc_out, inst_word};

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    checkCount++;
    if (cache_addr !== 32'h0) $display("FAIL reset_addr: got %h expected %h", cache_addr, 32'h0);
    else passCount++;
    checkCount++;
    if (headObs !== EMPTY_GROUP) $display("FAIL reset_head: got %h expected %h", headObs, EMPTY_GROUP);
    else passCount++;
    checkCount++;
    if (cache_rd !== 1'b1) $display("FAIL reset_rd: got %b expected 1", cache_rd);
    else passCount++;
    tick();
    tick();
    checkCount++;
    if ({cache_addr, out_valid} !== {32'h0, 1'b0}) $display("FAIL reset_hold: got %h/%b expected 0/0", cache_addr, out_valid);
    else passCount++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    cache_waitrequest = 1'b0;
    reset_n = 1'b1;
    #1;
    checkCount++;
    if ({cache_addr, out_valid} !== {32'h0, 1'b0}) $display("FAIL stream_first: got %h/%b expected 0/0", cache_addr, out_valid);
    else passCount++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      #1;
      checkCount++;
      if (cache_addr !== 32'(16*k)) $display("FAIL stream_addr%0d: got %h expected %h", k, cache_addr, 32'(16*k));
      else passCount++;
      checkCount++;
      if (headObs !== group(32'(16*(k-1)), 4'hF)) $display("FAIL stream_head%0d: got %h expected %h", k, headObs, group(32'(16*(k-1)), 4'hF));
      else passCount++;
    end
  endtask

  task automatic test_redirect();
    load_pc = 1'b1;
    new_pc = 32'h0000_010A;
    #1;
    checkCount++;
    if ({cache_rd, cache_addr} !== {1'b0, 32'h30}) $display("FAIL redir_rd: got %b/%h expected 0/30", cache_rd, cache_addr);
    else passCount++;
    tick();
    load_pc = 1'b0;
    new_pc = 32'h0;
    #1;
    checkCount++;
    if ({cache_addr, headObs} !== {32'h108, EMPTY_GROUP}) $display("FAIL redir_flush: got %h/%h expected 108/empty", cache_addr, headObs);
    else passCount++;
    tick();
    #1;
    checkCount++;
    if (headObs !== group(32'h100, 4'b1100)) $display("FAIL redir_group: got %h expected %h", headObs, group(32'h100, 4'b1100));
    else passCount++;
    checkCount++;
    if (cache_addr !== 32'h110) $display("FAIL redir_next: got %h expected %h", cache_addr, 32'h110);
    else passCount++;
    tick();
    #1;
    checkCount++;
    if ({cache_addr, headObs} !== {32'h120, group(32'h110, 4'hF)}) $display("FAIL redir_after: got %h/%h", cache_addr, headObs);
    else passCount++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    load_pc = 1'b1;
    new_pc = 32'h0;
    tick();
    load_pc = 1'b0;
    #1;
    for (int k = 0; k <= 6; k++) begin
      checkCount++;
      if (cache_addr !== ((k < 4) ? 32'(16*k) : 32'h40)) $display("FAIL bp_addr%0d: got %h", k, cache_addr);
      else passCount++;
      checkCount++;
      if (cache_rd !== (k < 4)) $display("FAIL bp_rd%0d: got %b expected %b", k, cache_rd, k < 4);
      else passCount++;
      checkCount++;
      if (headObs !== ((k == 0) ? EMPTY_GROUP : group(32'h0, 4'hF))) $display("FAIL bp_head%0d: got %h", k, headObs);
      else passCount++;
      if (k < 6) begin
        tick();
        #1;
      end
    end
    cache_waitrequest = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkCount++;
      if ({cache_addr, headObs} !== {32'h40, group(32'(16*k), 4'hF)}) $display("FAIL drain%0d: got %h/%h", k, cache_addr, headObs);
      else passCount++;
      tick();
      #1;
    end
    checkCount++;
    if (headObs !== EMPTY_GROUP) $display("FAIL drain_empty: got %h expected empty", headObs);
    else passCount++;
  endtask

  task automatic test_waitrequest();
    out_ready = 1'b0;
    cache_waitrequest = 1'b0;
    #1;
    checkCount++;
    if ({cache_rd, cache_addr} !== {1'b1, 32'h40}) $display("FAIL wait_req: got %b/%h expected 1/40", cache_rd, cache_addr);
    else passCount++;
    tick();
    cache_waitrequest = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkCount++;
      if ({cache_addr, headObs} !== {32'h50, group(32'h40, 4'hF)}) $display("FAIL wait_hold%0d: got %h/%h", k, cache_addr, headObs);
      else passCount++;
      tick();
      #1;
    end
  endtask

  task automatic test_full_redirect();
    cache_waitrequest = 1'b0;
    tick();
    tick();
    tick();
    #1;
    checkCount++;
    if ({cache_rd, cache_addr, headObs} !== {1'b0, 32'h80, group(32'h40, 4'hF)}) $display("FAIL full_state: got %b/%h/%h", cache_rd, cache_addr, headObs);
    else passCount++;
    out_ready = 1'b1;
    load_pc = 1'b1;
    new_pc = 32'h200;
    tick();
    load_pc = 1'b0;
    cache_waitrequest = 1'b1;
    #1;
    checkCount++;
    if ({cache_addr, headObs} !== {32'h200, EMPTY_GROUP}) $display("FAIL fullredir_flush: got %h/%h", cache_addr, headObs);
    else passCount++;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      checkCount++;
      if (headObs !== EMPTY_GROUP) $display("FAIL fullredir_stale%0d: got %h expected empty", k, headObs);
      else passCount++;
    end
    cache_waitrequest = 1'b0;
    tick();
    #1;
    checkCount++;
    if (headObs !== group(32'h200, 4'hF)) $display("FAIL fullredir_new: got %h expected %h", headObs, group(32'h200, 4'hF));
    else passCount++;
  endtask

  task automatic test_wrap();
    load_pc = 1'b1;
    new_pc = 32'hFFFF_FFF4;
    tick();
    load_pc = 1'b0;
    #1;
    checkCount++;
    if ({cache_addr, out_valid} !== {32'hFFFF_FFF4, 1'b0}) $display("FAIL wrap_addr: got %h/%b expected fffffff4/0", cache_addr, out_valid);
    else passCount++;
    tick();
    #1;
    checkCount++;
    if (headObs !== group(32'hFFFF_FFF0, 4'b1110)) $display("FAIL wrap_group: got %h expected %h", headObs, group(32'hFFFF_FFF0, 4'b1110));
    else passCount++;
    checkCount++;
    if (cache_addr !== 32'h0) $display("FAIL wrap_next: got %h expected 00000000", cache_addr);
    else passCount++;
    tick();
    #1;
    checkCount++;
    if (headObs !== group(32'h0, 4'hF)) $display("FAIL wrap_after: got %h expected %h", headObs, group(32'h0, 4'hF));
    else passCount++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    tick();
    tick();
    #1;
    checkCount++;
    if ({out_valid, cache_addr} !== {1'b1, 32'h30}) $display("FAIL areset_pre: got %b/%h expected 1/30", out_valid, cache_addr);
    else passCount++;
    reset_n = 1'b0;
    #1;
    checkCount++;
    if ({cache_addr, headObs} !== {32'h0, EMPTY_GROUP}) $display("FAIL areset_now: got %h/%h expected 0/empty", cache_addr, headObs);
    else passCount++;
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checkCount++;
    if ({cache_rd, cache_addr} !== {1'b1, 32'h0}) $display("FAIL areset_first: got %b/%h expected 1/0", cache_rd, cache_addr);
    else passCount++;
    tick();
    #1;
    checkCount++;
    if ({cache_addr, headObs} !== {32'h10, group(32'h0, 4'hF)}) $display("FAIL areset_group: got %h/%h", cache_addr, headObs);
    else passCount++;
  endtask

  initial begin
    $display("[TB] ifetch_queue directed bench start");
    test_reset();
    test_stream();
    test_redirect();
    test_backpressure();
    test_waitrequest();
    test_full_redirect();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
